// File: rtl/packet_priority_arbiter_n_if.sv
// Flit bus between N input producers and the single arbiter output.
interface packet_priority_arbiter_n_if #(
    parameter int N         = 4,
    parameter int FLIT_SIZE = 16,
    parameter int SEL_W     = (N > 1) ? $clog2(N) : 1
);
    logic [FLIT_SIZE*N-1:0] in;
    logic [N-1:0]           in_valid;
    logic [N-1:0]           in_avail;
    logic [FLIT_SIZE-1:0]   out;
    logic                   out_valid;
    logic                   out_avail;
    logic [SEL_W-1:0]       out_sel;
    logic                   locked;

    modport master (output in, in_valid, out_avail,
                    input  in_avail, out, out_valid, out_sel, locked);
    modport slave  (input  in, in_valid, out_avail,
                    output in_avail, out, out_valid, out_sel, locked);
endinterface

// File: rtl/packet_priority_arbiter_n.sv
// N-input wormhole flit arbiter: per-input queues, CMP priority, round-robin ties.
// Define ARB_AGING_EN to add saturating per-channel age counters against starvation.
module packet_priority_arbiter_n #(
    parameter int N          = 4,
    parameter int DEPTH_LOG  = 2,
    parameter int AGE_W      = 4,
    parameter int FLIT_SIZE  = 16,
    parameter int HEADER_LEN = 2,
    parameter int CMP_POS    = 8,
    parameter int CMP_LEN    = 4
) (
    input  logic clk,
    input  logic rst,
    packet_priority_arbiter_n_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
    localparam int KEY_W = CMP_LEN + 1;
    localparam logic [HEADER_LEN-1:0] T_SINGLE = HEADER_LEN'(0);
    localparam logic [HEADER_LEN-1:0] T_HEAD   = HEADER_LEN'(1);
    localparam logic [HEADER_LEN-1:0] T_BODY   = HEADER_LEN'(2);

    if (N < 1 || N > 16 || DEPTH_LOG < 1 || AGE_W < 1) begin : g_param_err
        $error("packet_priority_arbiter_n: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_BURST} state_t;

    state_t                r_state, w_nxt_state;
    logic [SEL_W-1:0]      r_sel, r_rr, w_nxt_sel, w_nxt_rr;
    logic [SEL_W-1:0]      w_win, w_sel, w_sel_inc;
    logic                  w_any, w_valid, w_xfer;
    logic [N-1:0]          w_push, w_pop, w_empty, w_full, w_elig, w_sat;
    logic [FLIT_SIZE-1:0]  w_head [N];
    logic [CMP_LEN-1:0]    w_cmp [N];
    logic [FLIT_SIZE-1:0]  w_out_flit;
    logic [HEADER_LEN-1:0] w_out_type;
    logic [KEY_W-1:0]      w_best, w_key;
    int                    w_idx;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_q
            logic [FLIT_SIZE-1:0]  r_mem [DEPTH];
            logic [DEPTH_LOG-1:0]  r_wp, r_rp;
            logic [DEPTH_LOG:0]    r_cnt;
            logic [HEADER_LEN-1:0] w_type;

            assign w_full[g]  = (r_cnt == (DEPTH_LOG+1)'(DEPTH));
            assign w_empty[g] = (r_cnt == '0);
            assign w_push[g]  = bus.in_valid[g] & ~w_full[g];
            assign w_pop[g]   = w_xfer & (w_sel == SEL_W'(g));
            assign w_head[g]  = r_mem[r_rp];
            assign w_type     = w_head[g][FLIT_SIZE-1 -: HEADER_LEN];
            assign w_cmp[g]   = w_head[g][CMP_POS +: CMP_LEN];
            assign w_elig[g]  = ~w_empty[g] & ((w_type == T_HEAD) | (w_type == T_SINGLE));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wp  <= '0;
                    r_rp  <= '0;
                    r_cnt <= '0;
                end else begin
                    if (w_push[g]) begin
                        r_mem[r_wp] <= bus.in[FLIT_SIZE*g +: FLIT_SIZE];
                        r_wp        <= r_wp + 1'b1;
                    end
                    if (w_pop[g]) r_rp <= r_rp + 1'b1;
                    r_cnt <= r_cnt + (DEPTH_LOG+1)'(w_push[g]) - (DEPTH_LOG+1)'(w_pop[g]);
                end
            end
        end
    endgenerate

`ifdef ARB_AGING_EN
    generate
        for (g = 0; g < N; g++) begin : g_age
            logic [AGE_W-1:0] r_age;
            assign w_sat[g] = &r_age;
            always_ff @(posedge clk) begin
                if (rst)
                    r_age <= '0;
                else if (w_pop[g])
                    r_age <= '0;
                else if (w_elig[g] && r_state != S_BURST && w_sel != SEL_W'(g) && !w_sat[g])
                    r_age <= r_age + 1'b1;
            end
        end
    endgenerate
`else
    assign w_sat = '0;
`endif

    // Scan from rr upward; strict '>' keeps the first tied channel. Saturated age outranks any CMP.
    always_comb begin
        w_win  = r_rr;
        w_any  = 1'b0;
        w_best = '0;
        w_key  = '0;
        w_idx  = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(r_rr) + k) % N;
            w_key = w_sat[w_idx] ? {1'b1, {CMP_LEN{1'b0}}} : {1'b0, w_cmp[w_idx]};
            if (w_elig[w_idx] && (!w_any || w_key > w_best)) begin
                w_any  = 1'b1;
                w_best = w_key;
                w_win  = SEL_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_rr    <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_sel   <= w_nxt_sel;
            r_rr    <= w_nxt_rr;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sel   = r_sel;
        w_nxt_rr    = r_rr;
        case (r_state)
            S_IDLE: if (w_any) begin
                w_nxt_sel = w_win;
                if (!w_xfer)                  w_nxt_state = S_HOLD;
                else if (w_out_type == T_HEAD) w_nxt_state = S_BURST;
                else                          w_nxt_rr    = w_sel_inc;
            end
            S_HOLD: if (w_xfer) begin
                if (w_out_type == T_HEAD) w_nxt_state = S_BURST;
                else begin
                    w_nxt_state = S_IDLE;
                    w_nxt_rr    = w_sel_inc;
                end
            end
            // Anything but BODY closes the burst, so a stray HEAD/SINGLE cannot wedge the lock.
            S_BURST: if (w_xfer && w_out_type != T_BODY) begin
                w_nxt_state = S_IDLE;
                w_nxt_rr    = w_sel_inc;
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_sel   = r_sel;
        w_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sel   = w_win;
                w_valid = w_any;
            end
            S_HOLD:  w_valid = 1'b1;
            S_BURST: w_valid = ~w_empty[r_sel];
            default: w_valid = 1'b0;
        endcase
    end

    assign w_xfer     = w_valid & bus.out_avail;
    assign w_out_flit = w_head[w_sel];
    assign w_out_type = w_out_flit[FLIT_SIZE-1 -: HEADER_LEN];
    assign w_sel_inc  = (w_sel == SEL_W'(N-1)) ? '0 : w_sel + 1'b1;

    assign bus.out       = w_valid ? w_out_flit : '0;
    assign bus.out_valid = w_valid;
    assign bus.out_sel   = w_sel;
    assign bus.locked    = (r_state == S_BURST);
    assign bus.in_avail  = ~w_full;
endmodule
